// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
//
// Shares an 8-digit seven-segment display between two independent writers.
// Holds an 8 x 4-bit hex digit buffer. It accepts single-digit writes from two
// requesters through a round-robin req/ack handshake. It also time-multiplexes
// the buffer onto the shared active-low digit-enable and segment lines.
//
// Parameters
//   SCAN_DIV : clock cycles each digit stays lit (>= 2)
//
// Ports
//   clk           : single clock, rising-edge
//   rst           : asynchronous active-high reset
//   a_req         : requester A write request, held until a_ack
//   a_idx[2:0]    : requester A target digit
//   a_data[3:0]   : requester A hex value
//   a_ack         : one-cycle pulse, A's write committed
//   b_req/b_idx/b_data/b_ack : requester B, same meaning as A
//   blank[7:0]    : per-digit blank mask, bit i = 1 suppresses digit i
//   led_en[7:0]   : digit enables, active-low one-hot
//   led[6:0]      : segments, active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg_display_arbiter #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic [2:0] a_idx,
    input  logic [3:0] a_data,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [2:0] b_idx,
    input  logic [3:0] b_data,
    output logic       b_ack,
    input  logic [7:0] blank,
    output logic [7:0] led_en,
    output logic [6:0] led
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]    buf_q [8];
    prio_t         prio_q;
    logic          a_ack_q;
    logic          b_ack_q;
    logic [PW-1:0] presc_q;
    logic [2:0]    digit_q;
    logic [7:0]    led_en_q;
    logic [6:0]    led_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // A port whose ack is currently high has just been served. Masking it
    // here stops a held req from writing a second time during its ack cycle.
    logic a_elig;
    logic b_elig;
    logic grant_a;
    logic grant_b;
    prio_t prio_d;

    assign a_elig  = a_req & ~a_ack_q;
    assign b_elig  = b_req & ~b_ack_q;
    assign grant_a = a_elig & (~b_elig | (prio_q == PRIO_A));
    assign grant_b = b_elig & (~a_elig | (prio_q == PRIO_B));

    always_comb begin
        prio_d = prio_q;
        if (grant_a) begin
            prio_d = PRIO_B;
        end else if (grant_b) begin
            prio_d = PRIO_A;
        end
    end

    // Write port into the digit buffer. At most one grant exists per cycle.
    logic       wr_any;
    logic [2:0] wr_idx;
    logic [3:0] wr_data;
    logic [7:0] wr_en;

    assign wr_any  = grant_a | grant_b;
    assign wr_idx  = grant_a ? a_idx  : b_idx;
    assign wr_data = grant_a ? a_data : b_data;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_wr_en
            assign wr_en[gi] = wr_any && (wr_idx == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_en[i]) begin
                    buf_q[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q  <= PRIO_A;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
        end else begin
            prio_q  <= prio_d;
            a_ack_q <= grant_a;
            b_ack_q <= grant_b;
        end
    end

    assign a_ack = a_ack_q;
    assign b_ack = b_ack_q;

    // ------------------------------------------------------------------
    // Scanner: prescaler and digit index
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_d;
    logic [2:0]    digit_d;

    always_comb begin
        presc_d = presc_q + 1'b1;
        digit_d = digit_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            digit_d = digit_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            digit_q <= 3'd0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
        end
    end

    // ------------------------------------------------------------------
    // Display decode, registered so the pins never glitch
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [7:0] led_en_d;
    logic [6:0] led_d;

    always_comb begin
        led_en_d = 8'hFF;
        led_d    = 7'h7F;
        if (!blank[digit_q]) begin
            led_en_d = ~(8'h01 << digit_q);
            led_d    = hex_font(buf_q[digit_q]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en_q <= 8'hFF;
            led_q    <= 7'h7F;
        end else begin
            led_en_q <= led_en_d;
            led_q    <= led_d;
        end
    end

    assign led_en = led_en_q;
    assign led    = led_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst;
    logic       a_req;
    logic [2:0] a_idx;
    logic [3:0] a_data;
    logic       a_ack;
    logic       b_req;
    logic [2:0] b_idx;
    logic [3:0] b_data;
    logic       b_ack;
    logic [7:0] blank;
    logic [7:0] led_en;
    logic [6:0] led;

    seg_display_arbiter #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_req  (a_req),
        .a_idx  (a_idx),
        .a_data (a_data),
        .a_ack  (a_ack),
        .b_req  (b_req),
        .b_idx  (b_idx),
        .b_data (b_data),
        .b_ack  (b_ack),
        .blank  (blank),
        .led_en (led_en),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: digit buffer, pointer, last acks, edges since reset.
    logic [6:0] font [16];
    logic [3:0] m_buf [8];
    int         m_prio;
    bit         m_aack;
    bit         m_back;
    int         k;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_buf[i] = 4'h0;
        m_prio = 0;
        m_aack = 0;
        m_back = 0;
        k      = 0;
    endtask

    // One clock edge: predict from pre-edge state, advance, compare.
    task automatic tick();
        int d;
        logic [7:0] e_en;
        logic [6:0] e_led;
        bit ea, eb, ga, gb;
        d = (k / SCAN_DIV) % 8;
        if (blank[d]) begin
            e_en  = 8'hFF;
            e_led = 7'h7F;
        end else begin
            e_en  = ~(8'h01 << d);
            e_led = font[m_buf[d]];
        end
        ea = a_req && !m_aack;
        eb = b_req && !m_back;
        ga = 0;
        gb = 0;
        if (ea && eb) begin
            if (m_prio == 0) ga = 1; else gb = 1;
        end else begin
            ga = ea;
            gb = eb;
        end
        if (ga) begin m_buf[a_idx] = a_data; m_prio = 1; end
        if (gb) begin m_buf[b_idx] = b_data; m_prio = 0; end
        m_aack = ga;
        m_back = gb;
        @(posedge clk);
        #1;
        k++;
        chk("led_en", led_en, e_en);
        chk("led", {1'b0, led}, {1'b0, e_led});
        chk("a_ack", {7'b0, a_ack}, {7'b0, m_aack});
        chk("b_ack", {7'b0, b_ack}, {7'b0, m_back});
        $display("edge %0d: a_req=%b b_req=%b a_ack=%b b_ack=%b led_en=%h led=%h",
                 k, a_req, b_req, a_ack, b_ack, led_en, led);
    endtask

    initial begin
        int  found;
        int  ff_cnt;
        bit  prev_a;

        font[0]  = 7'h40; font[1]  = 7'h79; font[2]  = 7'h24; font[3]  = 7'h30;
        font[4]  = 7'h19; font[5]  = 7'h12; font[6]  = 7'h02; font[7]  = 7'h78;
        font[8]  = 7'h00; font[9]  = 7'h10; font[10] = 7'h08; font[11] = 7'h03;
        font[12] = 7'h46; font[13] = 7'h21; font[14] = 7'h06; font[15] = 7'h0E;

        rst = 1'b1;
        a_req = 0; a_idx = 0; a_data = 0;
        b_req = 0; b_idx = 0; b_data = 0;
        blank = 8'h00;
        model_reset();

        // Reset state, both asynchronously and across clock edges.
        #2;
        chk("rst_led_en_async", led_en, 8'hFF);
        chk("rst_led_async", {1'b0, led}, 8'h7F);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_led_en", led_en, 8'hFF);
        chk("rst_led", {1'b0, led}, 8'h7F);
        chk("rst_a_ack", {7'b0, a_ack}, 8'h00);
        chk("rst_b_ack", {7'b0, b_ack}, 8'h00);
        rst = 1'b0;

        // First edge after release: digit 0 showing "0", held for SCAN_DIV cycles.
        tick();
        chk("first_led_en", led_en, 8'hFE);
        chk("first_led", {1'b0, led}, 8'h40);
        for (int i = 0; i < SCAN_DIV - 1; i++) tick();

        // Contention on idx 5: A granted first, then B; B's value wins.
        a_req = 1; a_idx = 3'd5; a_data = 4'h1;
        b_req = 1; b_idx = 3'd5; b_data = 4'h8;
        tick();
        chk("cont_a_first", {6'b0, a_ack, b_ack}, 8'h02);
        a_req = 0;
        tick();
        chk("cont_b_second", {6'b0, a_ack, b_ack}, 8'h01);
        b_req = 0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            if (led_en == 8'hDF) found = 1;
        end
        chk("cont_found_DF", led_en, 8'hDF);
        chk("cont_glyph_8", {1'b0, led}, 8'h00);

        // Single write: A writes idx 3 = A, ack lasts exactly one cycle.
        a_req = 1; a_idx = 3'd3; a_data = 4'hA;
        tick();
        chk("single_ack", {7'b0, a_ack}, 8'h01);
        a_req = 0;
        tick();
        chk("single_ack_drop", {7'b0, a_ack}, 8'h00);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            if (led_en == 8'hF7) found = 1;
        end
        chk("single_found_F7", led_en, 8'hF7);
        chk("single_glyph_A", {1'b0, led}, 8'h08);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if (!a_req || a_ack) begin
                a_req  = ($urandom_range(0, 3) != 0);
                a_idx  = 3'($urandom_range(0, 7));
                a_data = 4'($urandom_range(0, 15));
            end
            if (!b_req || b_ack) begin
                b_req  = ($urandom_range(0, 2) != 0);
                b_idx  = 3'($urandom_range(0, 7));
                b_data = 4'($urandom_range(0, 15));
            end
            if (n % 250 == 0) blank = 8'($urandom);
            tick();
        end
        a_req = 0; b_req = 0; blank = 8'h00;
        tick(); tick();

        // Fairness: both hold req continuously, grants strictly alternate.
        a_req = 1; a_idx = 3'd1; a_data = 4'h2;
        b_req = 1; b_idx = 3'd6; b_data = 4'h7;
        tick();
        prev_a = a_ack;
        for (int i = 0; i < 12; i++) begin
            a_data = 4'($urandom_range(0, 15));
            b_data = 4'($urandom_range(0, 15));
            tick();
            chk("fair_one_grant", {7'b0, a_ack ^ b_ack}, 8'h01);
            chk("fair_alternate", {7'b0, a_ack}, {7'b0, ~prev_a});
            prev_a = a_ack;
        end
        a_req = 0; b_req = 0;
        tick(); tick();

        // Blank digits 0 and 7: exactly 8 blanked cycles in any 32-cycle window.
        blank = 8'h81;
        tick();
        ff_cnt = 0;
        for (int i = 0; i < 8 * SCAN_DIV; i++) begin
            tick();
            if (led_en == 8'hFF) ff_cnt++;
        end
        chk("blank_count", 8'(ff_cnt), 8'(2 * SCAN_DIV));
        blank = 8'h00;

        // Reset mid-request: b_ack high, a_req pending, then reset.
        a_req = 0;
        b_req = 1; b_idx = 3'd2; b_data = 4'hF;
        tick();
        chk("mid_b_ack", {7'b0, b_ack}, 8'h01);
        a_req = 1; a_idx = 3'd4; a_data = 4'hC;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_b_ack_drop", {7'b0, b_ack}, 8'h00);
        chk("mid_a_ack", {7'b0, a_ack}, 8'h00);
        chk("mid_led_en", led_en, 8'hFF);
        chk("mid_led", {1'b0, led}, 8'h7F);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_hold_a_ack", {7'b0, a_ack}, 8'h00);
            chk("mid_hold_led_en", led_en, 8'hFF);
        end
        a_req = 0; b_req = 0;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8 * SCAN_DIV + 4; i++) begin
            tick();
            chk("post_rst_zero", {1'b0, led}, 8'h40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
